// File: rtl/parity_err_monitor.sv
// Dual-rail parity error monitor: rail validation, event counting, clear handshake.
// Self-test FSM is built only when PARITY_MON_SELFTEST_EN is defined.
module parity_err_monitor #(
  parameter int CNT_W      = 8,
  parameter int THRESH     = 4,
  parameter int ST_TIMEOUT = 16
) (
  input  logic             ACLK,
  input  logic             RESET_ACLK,
  input  logic             ERR_IN,
  input  logic             ERR_IN_B,
  output logic             ENERR_OUT,
  output logic             FIERR_OUT,
  input  logic             MON_EN,
  input  logic             CLR_REQ,
  output logic             CLR_ACK,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             RAIL_FAULT,
  output logic             IRQ_FATAL,
  input  logic             ST_START,
  output logic             ST_BUSY,
  output logic             ST_PASS,
  output logic             ST_FAIL
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic r_err, r_err_b, valid_d, eq_d;
  logic r_valid, r_idle, r_eq, rail_hit;
  logic evt, clr_pend, clr_do, st_busy;
  logic [CNT_W-1:0] cnt_base, cnt_inc;

  assign r_valid  = r_err & ~r_err_b;
  assign r_idle   = ~r_err & r_err_b;
  assign r_eq     = r_err ~^ r_err_b;
  // a single skewed cycle is tolerated; two in a row is a fault
  assign rail_hit = r_eq & eq_d;
  assign evt      = r_valid & ~valid_d & MON_EN & ~st_busy;
  assign clr_pend = CLR_REQ & ~CLR_ACK;
  assign clr_do   = clr_pend & ~st_busy;
  assign cnt_base = clr_do ? '0 : ERR_CNT;
  assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

  always_ff @(posedge ACLK) begin
    if (RESET_ACLK) begin
      r_err      <= 1'b0;
      r_err_b    <= 1'b1;
      valid_d    <= 1'b0;
      eq_d       <= 1'b0;
      ENERR_OUT  <= 1'b0;
      CLR_ACK    <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
      RAIL_FAULT <= 1'b0;
      IRQ_FATAL  <= 1'b0;
    end else begin
      r_err     <= ERR_IN;
      r_err_b   <= ERR_IN_B;
      valid_d   <= r_valid;
      eq_d      <= r_eq;
      ENERR_OUT <= MON_EN | st_busy;
      CLR_ACK   <= CLR_ACK ? CLR_REQ : clr_do;
      if (clr_do) begin
        ERR_STICKY <= 1'b0;
        ERR_CNT    <= '0;
        RAIL_FAULT <= 1'b0;
        IRQ_FATAL  <= 1'b0;
      end
      // event lands after the clear so a same-cycle pair leaves count 1
      if (evt) begin
        ERR_STICKY <= 1'b1;
        ERR_CNT    <= cnt_inc;
        if (cnt_inc >= THR)
          IRQ_FATAL <= 1'b1;
      end
      if (rail_hit) begin
        RAIL_FAULT <= 1'b1;
        IRQ_FATAL  <= 1'b1;
      end
    end
  end

`ifdef PARITY_MON_SELFTEST_EN
  typedef enum logic [1:0] {
    IDLE, INJECT, RELEASE, DONE
  } st_t;

  localparam int TW = $clog2(ST_TIMEOUT + 1);
  localparam logic [TW-1:0] TO = TW'(ST_TIMEOUT);

  st_t state, state_n;
  logic [TW-1:0] timer, timer_n, timer_inc;
  logic go, set_pass, set_fail, rf_seen;

  assign st_busy   = (state == INJECT) | (state == RELEASE);
  assign ST_BUSY   = st_busy;
  assign FIERR_OUT = (state == INJECT);
  assign timer_inc = timer + 1'b1;

  always_ff @(posedge ACLK) begin
    if (RESET_ACLK) begin
      state   <= IDLE;
      timer   <= '0;
      ST_PASS <= 1'b0;
      ST_FAIL <= 1'b0;
      rf_seen <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (go) begin
        ST_PASS <= 1'b0;
        ST_FAIL <= 1'b0;
        rf_seen <= 1'b0;
      end else if (rail_hit && st_busy) begin
        rf_seen <= 1'b1;
      end
      if (set_pass) ST_PASS <= 1'b1;
      if (set_fail) ST_FAIL <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    go       = 1'b0;
    set_pass = 1'b0;
    set_fail = 1'b0;
    unique case (state)
      IDLE: begin
        if (ST_START && !clr_pend) begin
          state_n = INJECT;
          timer_n = '0;
          go      = 1'b1;
        end
      end
      INJECT: begin
        if (r_valid) begin
          state_n = RELEASE;
          timer_n = '0;
        end else if (timer_inc == TO) begin
          state_n  = DONE;
          set_fail = 1'b1;
        end else begin
          timer_n = timer_inc;
        end
      end
      RELEASE: begin
        if (r_idle) begin
          state_n  = DONE;
          set_fail = rf_seen | rail_hit;
          set_pass = ~(rf_seen | rail_hit);
        end else if (timer_inc == TO) begin
          state_n  = DONE;
          set_fail = 1'b1;
        end else begin
          timer_n = timer_inc;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`else
  logic unused_cfg;

  assign unused_cfg = ST_START ^ (ST_TIMEOUT > 0);
  assign st_busy    = 1'b0;
  assign ST_BUSY    = 1'b0;
  assign FIERR_OUT  = 1'b0;
  assign ST_PASS    = 1'b0;
  assign ST_FAIL    = 1'b0;
`endif

endmodule
